// File: rtl/or4_operand_seq_if.sv
// Operand/result bundle between the upstream source, the or4 stage and the
// sequencer; the sequencer takes the slave view, the upstream/or4 side the master view.
interface or4_operand_seq_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] res;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] op_count;

  modport master (
    output din, din_valid, s, res_ready,
    input  din_ready, a, b, res, res_valid, op_count
  );

  modport slave (
    input  din, din_valid, s, res_ready,
    output din_ready, a, b, res, res_valid, op_count
  );
endinterface

// File: rtl/or4_operand_seq.sv
// Two-beat operand loader for or4, registered result and completed-op counter.
// Result valid 2 edges after B accept; upstream stalls in S_EVAL/S_OUT until res_ready.
module or4_operand_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  or4_operand_seq_if.slave  bus
);
  typedef enum logic [1:0] {S_A, S_B, S_EVAL, S_OUT} state_t;

  state_t           state, state_nxt;
  logic             a_ld, b_ld, res_ld, cnt_inc;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_A;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    a_ld      = 1'b0;
    b_ld      = 1'b0;
    res_ld    = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      S_A: begin
        if (bus.din_valid) begin
          a_ld      = 1'b1;
          state_nxt = S_B;
        end
      end
      S_B: begin
        if (bus.din_valid) begin
          b_ld      = 1'b1;
          state_nxt = S_EVAL;
        end
      end
      // or4 has had a full cycle to settle on the new b
      S_EVAL: begin
        res_ld    = 1'b1;
        state_nxt = S_OUT;
      end
      S_OUT: begin
        if (bus.res_ready) begin
          cnt_inc   = 1'b1;
          state_nxt = S_A;
        end
      end
      default: state_nxt = S_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      if (a_ld)    a_q   <= bus.din;
      if (b_ld)    b_q   <= bus.din;
      if (res_ld)  res_q <= bus.s;
      if (cnt_inc) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Handshake outputs depend on state only, never on inputs
  assign bus.din_ready = (state == S_A) || (state == S_B);
  assign bus.res_valid = (state == S_OUT);
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.res       = res_q;
  assign bus.op_count  = cnt_q;
endmodule
